// File: rtl/slip_pkg.sv
// SLIP framing constants shared by the transmit and receive paths.
// Holds the special characters, the encoder state type and the escape lookup.
package slip_pkg;

   // SLIP special characters
   localparam logic [7:0] CHAR_END     = 8'hC0;
   localparam logic [7:0] CHAR_ESC     = 8'hDB;
   localparam logic [7:0] CHAR_ESC_END = 8'hDC;
   localparam logic [7:0] CHAR_ESC_ESC = 8'hDD;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_BYTE  = 3'd2,
      ST_ESC2  = 3'd3,
      ST_NEXT  = 3'd4,
      ST_STOP  = 3'd5
   } slip_state_e;

   // True for bytes that must be sent as a two-byte escape
   function automatic logic slip_is_special(input logic [7:0] b);
      return (b == CHAR_END) || (b == CHAR_ESC);
   endfunction

   // Second byte of an escape: END -> ESC_END, ESC -> ESC_ESC
   function automatic logic [7:0] slip_esc_code(input logic [7:0] b);
      return (b == CHAR_END) ? CHAR_ESC_END : CHAR_ESC_ESC;
   endfunction

endpackage

// File: rtl/slip_tx.sv
// SLIP encoder: frames raw bytes with END and escapes END/ESC payload bytes.
// One-deep output slot feeds the UART transmitter over a valid/ack handshake.
module slip_tx
   import slip_pkg::*;
#(
   parameter bit SEND_SOF = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   output logic       frame,
   input  logic [7:0] din,
   input  logic       din_last,
   input  logic       din_rdy,
   output logic       din_ack,
   output logic [7:0] dout,
   output logic       dout_rdy,
   input  logic       dout_ack
);

   slip_state_e state_q;
   logic [7:0]  buf_q;
   logic        last_q;
   logic        frame_q;
   logic [7:0]  dout_q;
   logic        dout_rdy_q;
   logic        slot_free;

   // Output slot can take a new byte when empty or being drained this edge
   assign slot_free = !dout_rdy_q || dout_ack;

   // Input is accepted only while waiting for a frame byte
   assign din_ack = (state_q == ST_IDLE) || (state_q == ST_NEXT);

   assign frame    = frame_q;
   assign dout     = dout_q;
   assign dout_rdy = dout_rdy_q;

   // Encoder FSM with registered output slot and frame flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         buf_q      <= 8'h00;
         last_q     <= 1'b0;
         frame_q    <= 1'b0;
         dout_q     <= 8'h00;
         dout_rdy_q <= 1'b0;
      end else begin
         if (dout_rdy_q && dout_ack) begin
            dout_rdy_q <= 1'b0;
         end
         case (state_q)
            ST_IDLE: begin
               if (din_rdy) begin
                  buf_q   <= din;
                  last_q  <= din_last;
                  frame_q <= 1'b1;
                  state_q <= SEND_SOF ? ST_START : ST_BYTE;
               end
            end
            ST_START: begin
               if (slot_free) begin
                  dout_q     <= CHAR_END;
                  dout_rdy_q <= 1'b1;
                  state_q    <= ST_BYTE;
               end
            end
            ST_BYTE: begin
               if (slot_free) begin
                  dout_rdy_q <= 1'b1;
                  if (slip_is_special(buf_q)) begin
                     dout_q  <= CHAR_ESC;
                     state_q <= ST_ESC2;
                  end else begin
                     dout_q  <= buf_q;
                     state_q <= last_q ? ST_STOP : ST_NEXT;
                  end
               end
            end
            ST_ESC2: begin
               if (slot_free) begin
                  dout_q     <= slip_esc_code(buf_q);
                  dout_rdy_q <= 1'b1;
                  state_q    <= last_q ? ST_STOP : ST_NEXT;
               end
            end
            ST_NEXT: begin
               if (din_rdy) begin
                  buf_q   <= din;
                  last_q  <= din_last;
                  state_q <= ST_BYTE;
               end
            end
            ST_STOP: begin
               if (slot_free) begin
                  dout_q     <= CHAR_END;
                  dout_rdy_q <= 1'b1;
                  frame_q    <= 1'b0;
                  state_q    <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_slip_tx.sv
// Self-checking bench for slip_tx: directed frame table, backpressure,
// back-to-back, mid-frame reset, no-SOF variant and random traffic.
module tb_slip_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic       frame;
   logic [7:0] din;
   logic       din_last;
   logic       din_rdy;
   logic       din_ack;
   logic [7:0] dout;
   logic       dout_rdy;
   logic       dout_ack = 1'b1;

   logic       frame0;
   logic [7:0] din0;
   logic       din_last0;
   logic       din_rdy0;
   logic       din_ack0;
   logic [7:0] dout0;
   logic       dout_rdy0;
   logic       dout_ack0 = 1'b1;

   always #5 clk = ~clk;

   slip_tx #(.SEND_SOF(1'b1)) dut (
      .clk(clk), .rst(rst), .frame(frame),
      .din(din), .din_last(din_last),
      .din_rdy(din_rdy), .din_ack(din_ack),
      .dout(dout), .dout_rdy(dout_rdy),
      .dout_ack(dout_ack)
   );

   slip_tx #(.SEND_SOF(1'b0)) dut0 (
      .clk(clk), .rst(rst), .frame(frame0),
      .din(din0), .din_last(din_last0),
      .din_rdy(din_rdy0), .din_ack(din_ack0),
      .dout(dout0), .dout_rdy(dout_rdy0),
      .dout_ack(dout_ack0)
   );

   int n_cmp = 0;
   int n_fail = 0;
   int ack_mode = 0;
   logic [7:0] capq[$];
   logic [7:0] cap0[$];
   logic [7:0] expq[$];
   logic       stall_q = 1'b0;
   logic [7:0] stall_d = 8'h00;

   typedef struct {
      int         len;
      logic [7:0] b [0:3];
      int         elen;
      logic [7:0] e [0:9];
   } vec_t;
   vec_t tbl [0:2];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Reference encoder: applies the SLIP rules to a whole frame
   function automatic void enc(input logic [7:0] f[$], input bit sof);
      if (sof) expq.push_back(8'hC0);
      foreach (f[i]) begin
         if (f[i] == 8'hC0) begin
            expq.push_back(8'hDB);
            expq.push_back(8'hDC);
         end else if (f[i] == 8'hDB) begin
            expq.push_back(8'hDB);
            expq.push_back(8'hDD);
         end else begin
            expq.push_back(f[i]);
         end
      end
      expq.push_back(8'hC0);
   endfunction

   // Output capture and hold-while-stalled checker
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && dout_rdy && dout_ack) capq.push_back(dout);
         if (!rst && dout_rdy0 && dout_ack0) cap0.push_back(dout0);
         if (!rst && stall_q) begin
            chk("hold_rdy", {31'd0, dout_rdy}, 32'd1);
            chk("hold_dout", {24'd0, dout}, {24'd0, stall_d});
         end
         stall_q = !rst && dout_rdy && !dout_ack;
         stall_d = dout;
      end
   end

   // Consumer ready pattern
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ack_mode)
            0: dout_ack = 1'b1;
            1: dout_ack = ($urandom % 3) != 0;
            default: dout_ack = 1'b0;
         endcase
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic l);
      int n = 0;
      logic acc = 1'b0;
      din = b;
      din_last = l;
      din_rdy = 1'b1;
      do begin
         @(negedge clk);
         acc = din_ack;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 500);
      chk("din_accept", {31'd0, acc}, 32'd1);
      din_rdy = 1'b0;
      din_last = 1'b0;
      din = 8'($urandom);
   endtask

   task automatic send_frame(input logic [7:0] f[$]);
      foreach (f[i]) send_byte(f[i], i == f.size() - 1);
   endtask

   task automatic wait_cap(input int n);
      int k = 0;
      while (capq.size() < n && k < 5000) begin
         @(posedge clk);
         #1;
         k++;
      end
   endtask

   task automatic check_stream(input string nm);
      int m;
      wait_cap(expq.size());
      chk({nm, "_len"}, capq.size(), expq.size());
      m = capq.size() < expq.size() ? capq.size() : expq.size();
      for (int i = 0; i < m; i++)
         chk({nm, "_byte"}, {24'd0, capq[i]}, {24'd0, expq[i]});
      repeat (2) @(posedge clk);
      #1;
      chk({nm, "_frame_end"}, {31'd0, frame}, 32'd0);
      capq.delete();
      expq.delete();
   endtask

   initial begin
      logic [7:0] f[$];
      logic [7:0] snap;
      int k;

      tbl[0].len = 2;
      tbl[0].b = '{8'h01, 8'h02, 8'h00, 8'h00};
      tbl[0].elen = 4;
      tbl[0].e = '{8'hC0, 8'h01, 8'h02, 8'hC0, 8'h00,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      tbl[1].len = 3;
      tbl[1].b = '{8'hC0, 8'hDB, 8'h55, 8'h00};
      tbl[1].elen = 7;
      tbl[1].e = '{8'hC0, 8'hDB, 8'hDC, 8'hDB, 8'hDD,
                   8'h55, 8'hC0, 8'h00, 8'h00, 8'h00};
      tbl[2].len = 1;
      tbl[2].b = '{8'h7E, 8'h00, 8'h00, 8'h00};
      tbl[2].elen = 3;
      tbl[2].e = '{8'hC0, 8'h7E, 8'hC0, 8'h00,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

      rst = 1'b1;
      din = 8'h00; din_last = 1'b0; din_rdy = 1'b0;
      din0 = 8'h00; din_last0 = 1'b0; din_rdy0 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_dout_rdy", {31'd0, dout_rdy}, 32'd0);
      chk("rst_frame", {31'd0, frame}, 32'd0);
      chk("rst_dout", {24'd0, dout}, 32'd0);
      chk("rst_din_ack", {31'd0, din_ack}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Directed frame table
      for (int t = 0; t < 3; t++) begin
         for (int i = 0; i < tbl[t].len; i++) begin
            send_byte(tbl[t].b[i], i == tbl[t].len - 1);
            if (i == 0) chk("frame_hi", {31'd0, frame}, 32'd1);
         end
         for (int j = 0; j < tbl[t].elen; j++)
            expq.push_back(tbl[t].e[j]);
         check_stream($sformatf("tbl%0d", t));
      end

      // Backpressure mid-frame
      f = '{8'h11, 8'hC0, 8'h22, 8'h33};
      enc(f, 1'b1);
      fork
         send_frame(f);
         begin
            k = 0;
            while (capq.size() < 2 && k < 500) begin
               @(posedge clk);
               k++;
            end
            ack_mode = 2;
            repeat (4) @(negedge clk);
            snap = dout;
            for (int c = 0; c < 10; c++) begin
               @(negedge clk);
               chk("bp_dout", {24'd0, dout}, {24'd0, snap});
               chk("bp_rdy", {31'd0, dout_rdy}, 32'd1);
               chk("bp_din_ack", {31'd0, din_ack}, 32'd0);
            end
            ack_mode = 0;
         end
      join
      check_stream("bp");

      // Back-to-back single-byte frames
      send_byte(8'hAA, 1'b1);
      send_byte(8'hBB, 1'b1);
      f = '{8'hAA};
      enc(f, 1'b1);
      f = '{8'hBB};
      enc(f, 1'b1);
      check_stream("b2b");

      // Reset mid-frame
      send_byte(8'h01, 1'b0);
      wait_cap(2);
      chk("mr_len", capq.size(), 2);
      if (capq.size() >= 2) begin
         chk("mr_b0", {24'd0, capq[0]}, 32'hC0);
         chk("mr_b1", {24'd0, capq[1]}, 32'h01);
      end
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("mr_rdy", {31'd0, dout_rdy}, 32'd0);
      chk("mr_frame", {31'd0, frame}, 32'd0);
      @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("mr_din_ack", {31'd0, din_ack}, 32'd1);
      capq.delete();
      expq.delete();
      f = '{8'h7E};
      send_frame(f);
      enc(f, 1'b1);
      check_stream("mr_new");

      // Variant without leading END
      din0 = 8'hC0;
      din_last0 = 1'b1;
      din_rdy0 = 1'b1;
      @(posedge clk);
      #1;
      din_rdy0 = 1'b0;
      din0 = 8'h00;
      k = 0;
      while (cap0.size() < 3 && k < 200) begin
         @(posedge clk);
         k++;
      end
      chk("nosof_len", cap0.size(), 3);
      if (cap0.size() >= 3) begin
         chk("nosof_b0", {24'd0, cap0[0]}, 32'hDB);
         chk("nosof_b1", {24'd0, cap0[1]}, 32'hDC);
         chk("nosof_b2", {24'd0, cap0[2]}, 32'hC0);
      end

      // Random frames with random consumer stalls
      @(posedge clk);
      #1;
      ack_mode = 1;
      for (int fr = 0; fr < 20; fr++) begin
         f.delete();
         for (int i = 0; i < 1 + $urandom_range(0, 5); i++) begin
            case ($urandom % 4)
               0: f.push_back(8'hC0);
               1: f.push_back(8'hDB);
               default: f.push_back(8'($urandom));
            endcase
         end
         enc(f, 1'b1);
         send_frame(f);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
      wait_cap(expq.size());
      ack_mode = 0;
      check_stream("rand");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_fail);
      $finish;
   end

endmodule
